nios_system_key_event_ctrl: RTL and testbench



---
 rtl/nios_system_key_event_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_nios_system_key_event_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_system_key_event_ctrl.sv
// Avalon-MM master that services the Keys PIO: programs irq_mask, reads and clears
// edge-capture on irq, and queues timestamped key events in a small valid/ready FIFO.
module nios_system_key_event_ctrl #(
  parameter logic [3:0]  MASK_INIT  = 4'hF,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TS_W       = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            pio_irq,
  output logic [1:0]      pio_address,
  output logic            pio_chipselect,
  output logic            pio_write_n,
  output logic [31:0]     pio_writedata,
  input  logic [31:0]     pio_readdata,
  input  logic [3:0]      mask_in,
  input  logic            mask_load,
  output logic            evt_valid,
  output logic [TS_W+7:0] evt_data,
  input  logic            evt_ready,
  output logic            evt_ovf,
  input  logic            ovf_clr
);

  localparam int unsigned EW = TS_W + 8;
  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FullCnt = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [3:0] {
    StInit, StIdle, StMaskWr, StCapAddr, StCapLat, StDatAddr, StDatLat, StClear, StPush
  } state_e;

  state_e          state_q;
  logic            mask_pend_q;
  logic [3:0]      mask_q;
  logic [3:0]      cap_q;
  logic [3:0]      lvl_q;
  logic [TS_W-1:0] ts_q;
  logic [TS_W-1:0] ts_reg_q;

  logic [EW-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  logic            push_req, pop, full, push_ok, drop;
  logic [EW-1:0]   push_data;
  logic [3:0]      rd_nib;

  logic            cs_dec, wr_n_dec;
  logic [1:0]      addr_dec;
  logic [31:0]     wdata_dec;

  logic            unused_rd;
  assign unused_rd = ^pio_readdata[31:4];
  assign rd_nib    = pio_readdata[3:0];

  // Bus decode from the state register; forced idle while reset is held.
  always_comb begin
    cs_dec    = 1'b0;
    wr_n_dec  = 1'b1;
    addr_dec  = 2'd0;
    wdata_dec = 32'd0;
    unique case (state_q)
      StInit: begin
        cs_dec = 1'b1; wr_n_dec = 1'b0; addr_dec = 2'd2; wdata_dec = {28'd0, MASK_INIT};
      end
      StMaskWr: begin
        cs_dec = 1'b1; wr_n_dec = 1'b0; addr_dec = 2'd2; wdata_dec = {28'd0, mask_q};
      end
      StCapAddr: begin
        cs_dec = 1'b1; addr_dec = 2'd3;
      end
      StDatAddr: begin
        cs_dec = 1'b1; addr_dec = 2'd0;
      end
      StClear: begin
        cs_dec = 1'b1; wr_n_dec = 1'b0; addr_dec = 2'd3;
      end
      default: ;
    endcase
  end

  assign pio_chipselect = cs_dec & reset_n;
  assign pio_write_n    = wr_n_dec | ~reset_n;
  assign pio_address    = addr_dec & {2{reset_n}};
  assign pio_writedata  = wdata_dec & {32{reset_n}};

  assign evt_valid = (cnt_q != '0);
  assign evt_data  = mem_q[rd_ptr_q];
  assign evt_ovf   = ovf_q;

  assign push_req  = (state_q == StPush);
  assign pop       = evt_valid && evt_ready;
  assign full      = (cnt_q == FullCnt);
  assign push_ok   = push_req && (!full || pop);
  assign drop      = push_req && full && !pop;
  assign push_data = {ts_reg_q, cap_q, lvl_q};

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (ovf_clr) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StInit;
      mask_pend_q <= 1'b0;
      mask_q      <= 4'd0;
      cap_q       <= 4'd0;
      lvl_q       <= 4'd0;
      ts_q        <= '0;
      ts_reg_q    <= '0;
    end else begin
      ts_q <= ts_q + TS_W'(1);
      // A load in the MASK_WR cycle itself must survive for the next write.
      if (mask_load) begin
        mask_pend_q <= 1'b1;
        mask_q      <= mask_in;
      end else if (state_q == StMaskWr) begin
        mask_pend_q <= 1'b0;
      end
      unique case (state_q)
        StInit:    state_q <= StIdle;
        StIdle: begin
          if (mask_pend_q) begin
            state_q <= StMaskWr;
          end else if (pio_irq) begin
            state_q <= StCapAddr;
          end
        end
        StMaskWr:  state_q <= StIdle;
        StCapAddr: state_q <= StCapLat;
        StCapLat: begin
          cap_q    <= rd_nib;
          ts_reg_q <= ts_q;
          state_q  <= (rd_nib == 4'd0) ? StClear : StDatAddr;
        end
        StDatAddr: state_q <= StDatLat;
        StDatLat: begin
          lvl_q   <= rd_nib;
          state_q <= StClear;
        end
        StClear:   state_q <= (cap_q != 4'd0) ? StPush : StIdle;
        StPush:    state_q <= StIdle;
        default:   state_q <= StInit;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

endmodule

// File: tb/tb_nios_system_key_event_ctrl.sv
// Directed bench for the key event controller, with a behavioural 4-bit Keys PIO
// (falling-edge capture, write-to-clear, registered readdata).
module tb_nios_system_key_event_ctrl;

  logic        clk;
  logic        reset_n;
  logic        pio_rst_n;
  logic        pio_irq;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic [3:0]  mask_in;
  logic        mask_load;
  logic        evt_valid;
  logic [23:0] evt_data;
  logic        evt_ready;
  logic        evt_ovf;
  logic        ovf_clr;

  logic [3:0]  in_port, s1, s2, ecap, pmask;
  logic [15:0] cyc;

  int tests;
  int fails;

  nios_system_key_event_ctrl #(
    .MASK_INIT (4'hF),
    .FIFO_DEPTH(4),
    .TS_W      (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .pio_irq       (pio_irq),
    .pio_address   (pio_address),
    .pio_chipselect(pio_chipselect),
    .pio_write_n   (pio_write_n),
    .pio_writedata (pio_writedata),
    .pio_readdata  (pio_readdata),
    .mask_in       (mask_in),
    .mask_load     (mask_load),
    .evt_valid     (evt_valid),
    .evt_data      (evt_data),
    .evt_ready     (evt_ready),
    .evt_ovf       (evt_ovf),
    .ovf_clr       (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keys PIO model; it has its own reset so edge-capture survives a controller reset.
  always_ff @(posedge clk or negedge pio_rst_n) begin
    if (!pio_rst_n) begin
      s1 <= 4'hF; s2 <= 4'hF; ecap <= 4'h0; pmask <= 4'h0; pio_readdata <= 32'd0;
    end else begin
      s1 <= in_port;
      s2 <= s1;
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3) ecap <= 4'h0;
      else ecap <= ecap | (s2 & ~s1);
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pmask <= pio_writedata[3:0];
      case (pio_address)
        2'd0:    pio_readdata <= {28'd0, s1};
        2'd2:    pio_readdata <= {28'd0, pmask};
        2'd3:    pio_readdata <= {28'd0, ecap};
        default: pio_readdata <= 32'd0;
      endcase
    end
  end
  assign pio_irq = |(ecap & pmask);

  // Reference for the timestamp: cycles since reset release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 16'd0;
    else cyc <= cyc + 16'd1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_irq(input string tag, output logic [15:0] tsn);
    logic found;
    found = 1'b0;
    tsn   = 16'd0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (pio_irq) begin
        found = 1'b1;
        tsn   = cyc;
      end
    end
    chk(tag, {31'd0, found}, 32'd1);
  endtask

  // Press one key, follow the service to n+7, release, settle 3 cycles.
  task automatic press_evt(input logic [3:0] pin, input string tag, output logic [23:0] exp);
    logic [15:0] tsn;
    logic [3:0]  capv;
    in_port = pin;
    wait_irq(tag, tsn);
    capv = ~pin;
    exp  = {tsn + 16'd2, capv, pin};
    repeat (7) tick();
    in_port = 4'hF;
    repeat (3) tick();
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
  endtask

  logic [23:0] exp_q [5];
  logic [23:0] e;
  logic [15:0] tsn;
  logic        seen;
  logic [3:0]  keys [5];

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tests = 0; fails = 0;
    reset_n = 1'b0; pio_rst_n = 1'b0; in_port = 4'hF;
    mask_in = 4'h0; mask_load = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
    keys[0] = 4'hE; keys[1] = 4'hD; keys[2] = 4'hB; keys[3] = 4'h7; keys[4] = 4'hE;
    repeat (3) tick();
    pio_rst_n = 1'b1;
    tick();
    chk("rst_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("rst_wr_n", {31'd0, pio_write_n}, 32'd1);
    chk("rst_addr", {30'd0, pio_address}, 32'd0);
    chk("rst_valid", {31'd0, evt_valid}, 32'd0);
    chk("rst_ovf", {31'd0, evt_ovf}, 32'd0);
    chk("rst_data", {8'd0, evt_data}, 32'd0);

    // Reset release: one INIT write of the default mask, then IDLE.
    @(posedge clk); #1 reset_n = 1'b1; #1;
    chk("init_cs", {31'd0, pio_chipselect}, 32'd1);
    chk("init_wr_n", {31'd0, pio_write_n}, 32'd0);
    chk("init_addr", {30'd0, pio_address}, 32'd2);
    chk("init_wdata", pio_writedata, 32'hF);
    tick(); tick();
    chk("idle_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("pio_mask_init", {28'd0, pmask}, 32'hF);

    // Single key1 press with full cycle-by-cycle service trace.
    in_port = 4'hD;
    wait_irq("k1_irq", tsn);
    tick();
    chk("k1_capaddr_cs", {31'd0, pio_chipselect}, 32'd1);
    chk("k1_capaddr_wr_n", {31'd0, pio_write_n}, 32'd1);
    chk("k1_capaddr_addr", {30'd0, pio_address}, 32'd3);
    tick();
    chk("k1_caplat_cs", {31'd0, pio_chipselect}, 32'd0);
    tick();
    chk("k1_dataddr_cs", {31'd0, pio_chipselect}, 32'd1);
    chk("k1_dataddr_addr", {30'd0, pio_address}, 32'd0);
    tick(); tick();
    chk("k1_clear_wr_n", {31'd0, pio_write_n}, 32'd0);
    chk("k1_clear_addr", {30'd0, pio_address}, 32'd3);
    chk("k1_clear_wdata", pio_writedata, 32'd0);
    tick();
    chk("k1_push_irq", {31'd0, pio_irq}, 32'd0);
    chk("k1_push_valid", {31'd0, evt_valid}, 32'd0);
    tick();
    e = {tsn + 16'd2, 4'h2, 4'hD};
    chk("k1_valid", {31'd0, evt_valid}, 32'd1);
    chk("k1_data", {8'd0, evt_data}, {8'd0, e});
    tick();
    chk("k1_hold_data", {8'd0, evt_data}, {8'd0, e});
    chk("k1_idle_cs", {31'd0, pio_chipselect}, 32'd0);
    pop_one();
    chk("k1_pop_empty", {31'd0, evt_valid}, 32'd0);
    in_port = 4'hF;
    repeat (6) tick();
    chk("k1_release_noirq", {31'd0, pio_irq}, 32'd0);

    // Mask write timing and effect.
    mask_in = 4'h1; mask_load = 1'b1;
    tick();
    mask_load = 1'b0;
    chk("mask_k1_cs", {31'd0, pio_chipselect}, 32'd0);
    tick();
    chk("mask_wr_wr_n", {31'd0, pio_write_n}, 32'd0);
    chk("mask_wr_addr", {30'd0, pio_address}, 32'd2);
    chk("mask_wr_wdata", pio_writedata, 32'h1);
    tick();
    chk("mask_pio", {28'd0, pmask}, 32'h1);
    press_evt(4'hE, "mask_k0_irq", e);
    chk("mask_k0_data", {8'd0, evt_data}, {8'd0, e});
    chk("mask_k0_cap", {28'd0, evt_data[7:4]}, 32'h1);
    pop_one();
    in_port = 4'hB;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      seen = seen | pio_irq | evt_valid | (pio_chipselect & pio_write_n);
    end
    chk("mask_k2_quiet", {31'd0, seen}, 32'd0);
    in_port = 4'hF;
    repeat (3) tick();
    // Unmasking exposes the key2 edge that was captured while masked.
    mask_in = 4'hF; mask_load = 1'b1;
    tick();
    mask_load = 1'b0;
    wait_irq("unmask_irq", tsn);
    repeat (7) tick();
    chk("unmask_data", {8'd0, evt_data}, {8'd0, tsn + 16'd2, 4'h4, 4'hF});
    pop_one();

    // Overflow: five events into a four-deep FIFO with the consumer stalled.
    for (int i = 0; i < 5; i++) begin
      press_evt(keys[i], $sformatf("ovf_irq%0d", i), exp_q[i]);
      if (i == 3) chk("ovf_not_yet", {31'd0, evt_ovf}, 32'd0);
    end
    chk("ovf_set", {31'd0, evt_ovf}, 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    chk("ovf_clr", {31'd0, evt_ovf}, 32'd0);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("ovf_drain_valid%0d", i), {31'd0, evt_valid}, 32'd1);
      chk($sformatf("ovf_drain_data%0d", i), {8'd0, evt_data}, {8'd0, exp_q[i]});
      tick();
    end
    evt_ready = 1'b0;
    chk("ovf_drain_empty", {31'd0, evt_valid}, 32'd0);

    // Full FIFO with a pop in the PUSH cycle accepts the new event.
    for (int i = 0; i < 4; i++) press_evt(keys[i], $sformatf("full_irq%0d", i), exp_q[i]);
    in_port = 4'hE;
    wait_irq("full_irq4", tsn);
    exp_q[4] = {tsn + 16'd2, 4'h1, 4'hE};
    repeat (6) tick();
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    chk("full_pop_no_ovf", {31'd0, evt_ovf}, 32'd0);
    in_port = 4'hF;
    repeat (3) tick();
    evt_ready = 1'b1;
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("full_drain_data%0d", i), {8'd0, evt_data}, {8'd0, exp_q[i]});
      tick();
    end
    evt_ready = 1'b0;
    chk("full_drain_empty", {31'd0, evt_valid}, 32'd0);

    // mask_pend and irq visible in the same IDLE cycle: mask write goes first.
    in_port = 4'hD;
    tick();
    mask_in = 4'hF; mask_load = 1'b1;
    tick();
    mask_load = 1'b0;
    chk("both_irq", {31'd0, pio_irq}, 32'd1);
    chk("both_idle_cs", {31'd0, pio_chipselect}, 32'd0);
    tick();
    chk("both_maskwr_wr_n", {31'd0, pio_write_n}, 32'd0);
    chk("both_maskwr_addr", {30'd0, pio_address}, 32'd2);
    tick();
    chk("both_idle2_cs", {31'd0, pio_chipselect}, 32'd0);
    tsn = cyc;
    tick();
    chk("both_capaddr_addr", {30'd0, pio_address}, 32'd3);
    chk("both_capaddr_wr_n", {31'd0, pio_write_n}, 32'd1);
    repeat (6) tick();
    chk("both_data", {8'd0, evt_data}, {8'd0, tsn + 16'd2, 4'h2, 4'hD});
    in_port = 4'hF;
    pop_one();
    repeat (3) tick();

    // Reset in DAT_LAT discards the FIFO and the in-flight event; capture is re-serviced once.
    press_evt(4'h7, "rst_pre_irq", e);
    chk("rst_pre_valid", {31'd0, evt_valid}, 32'd1);
    in_port = 4'hB;
    wait_irq("rst_irq", tsn);
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cs", {31'd0, pio_chipselect}, 32'd0);
    chk("rst_mid_wr_n", {31'd0, pio_write_n}, 32'd1);
    chk("rst_mid_valid", {31'd0, evt_valid}, 32'd0);
    in_port = 4'hF;
    repeat (3) tick();
    @(posedge clk); #1 reset_n = 1'b1; #1;
    chk("rst_init_cs", {31'd0, pio_chipselect}, 32'd1);
    chk("rst_init_addr", {30'd0, pio_address}, 32'd2);
    tick(); tick();
    chk("rst_pending_irq", {31'd0, pio_irq}, 32'd1);
    tsn = cyc;
    repeat (7) tick();
    chk("rst_resvc_valid", {31'd0, evt_valid}, 32'd1);
    chk("rst_resvc_data", {8'd0, evt_data}, {8'd0, tsn + 16'd2, 4'h4, 4'hF});
    pop_one();
    seen = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      seen = seen | pio_irq | evt_valid;
    end
    chk("rst_once_only", {31'd0, seen}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
